// File: rtl/fpu_op_sequencer.sv
// Issue/latency sequencer for the multi-cycle FPU: stalls EX for a per-op table latency, then
// presents the captured unit result for one cycle. Optional perf counters: FPU_SEQ_PERF_CNT_EN.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// BUSY  | op in flight, count down to capture
// DONE  | result_valid cycle, may accept the next op back-to-back
module fpu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 10,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 5,
  parameter logic [NUM_OPS*CNT_W-1:0] LAT_TABLE =
    {5'd6, 5'd6, 5'd1, 5'd16, 5'd1, 5'd0, 5'd6, 5'd5, 5'd7, 5'd7}
) (
  input  logic                     clock,
  input  logic                     clock_reset,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [OP_W-1:0]          issue_op,
  output logic                     issue_ready,
  input  logic [NUM_OPS*WIDTH-1:0] unit_results,
  output logic                     fpu_inprogress,
  output logic                     result_valid,
  output logic [WIDTH-1:0]         fpu_result,
  output logic                     illegal_op,
  output logic [OP_W-1:0]          busy_op,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             fire;
  logic             op_legal;
  logic [CNT_W-1:0] issue_lat;
  logic [WIDTH-1:0] issue_res;
  logic [WIDTH-1:0] busy_res;

  assign issue_ready    = (state != BUSY);
  assign fire           = issue_valid & issue_ready & ~flush;
  assign fpu_inprogress = fire | (state == BUSY);
  assign op_legal       = (32'(issue_op) < 32'(NUM_OPS));

  // Out-of-range op codes match no slot, so they resolve to latency 0 and a zero result.
  always_comb begin
    issue_lat = '0;
    issue_res = '0;
    busy_res  = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (issue_op == OP_W'(k)) begin
        issue_lat = LAT_TABLE[k*CNT_W +: CNT_W];
        issue_res = unit_results[k*WIDTH +: WIDTH];
      end
      if (busy_op == OP_W'(k)) busy_res = unit_results[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or negedge clock_reset) begin
    if (!clock_reset) begin
      state        <= IDLE;
      count        <= '0;
      fpu_result   <= '0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      busy_op      <= '0;
    end else begin
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        count   <= '0;
        busy_op <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (fire) begin
              if (issue_lat == '0) begin
                fpu_result   <= issue_res;
                result_valid <= 1'b1;
                illegal_op   <= ~op_legal;
                busy_op      <= '0;
                state        <= DONE;
              end else begin
                count   <= issue_lat;
                busy_op <= issue_op;
                state   <= BUSY;
              end
            end else begin
              busy_op <= '0;
              state   <= IDLE;
            end
          end
          BUSY: begin
            // Upstream holds operands, so the unit output for busy_op is final by the last count.
            if (count <= CNT_W'(1)) begin
              fpu_result   <= busy_res;
              result_valid <= 1'b1;
              count        <= '0;
              busy_op      <= '0;
              state        <= DONE;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
          default: begin
            count   <= '0;
            busy_op <= '0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FPU_SEQ_PERF_CNT_EN
  // Not cleared by flush: these track lifetime activity since reset.
  always_ff @(posedge clock or negedge clock_reset) begin
    if (!clock_reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (result_valid)   perf_ops   <= perf_ops + 32'd1;
      if (fpu_inprogress) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: latency timing, back-to-back, illegal op, flush, reset, perf.
module tb_fpu_op_sequencer;
  localparam int WIDTH = 32;
  localparam int NUM_OPS = 10;
  localparam int OP_W = 4;

  logic                     clock = 1'b0;
  logic                     clock_reset;
  logic                     flush;
  logic                     issue_valid;
  logic [OP_W-1:0]          issue_op;
  logic                     issue_ready;
  logic [NUM_OPS*WIDTH-1:0] unit_results;
  logic                     fpu_inprogress;
  logic                     result_valid;
  logic [WIDTH-1:0]         fpu_result;
  logic                     illegal_op;
  logic [OP_W-1:0]          busy_op;
  logic [31:0]              perf_ops;
  logic [31:0]              perf_stall;

  int n_asserts = 0;
  int n_fail = 0;

  fpu_op_sequencer dut (
    .clock(clock), .clock_reset(clock_reset), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_ready(issue_ready),
    .unit_results(unit_results), .fpu_inprogress(fpu_inprogress),
    .result_valid(result_valid), .fpu_result(fpu_result), .illegal_op(illegal_op),
    .busy_op(busy_op), .perf_ops(perf_ops), .perf_stall(perf_stall)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] slot(input int k);
    return 32'h3F80_0000 + 32'(k) * 32'h0001_1111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues op in the current cycle T and checks every cycle through the DONE cycle T+lat+1.
  task automatic do_op(input logic [OP_W-1:0] op, input int lat, input logic [31:0] res,
                       input logic ill);
    issue_valid = 1'b1;
    issue_op    = op;
    #1;
    check("issue_ready_T", 32'(issue_ready), 32'd1);
    check("inprogress_T", 32'(fpu_inprogress), 32'd1);
    tick();
    issue_valid = 1'b0;
    issue_op    = '0;
    for (int i = 1; i <= lat; i++) begin
      #1;
      check("inprogress_busy", 32'(fpu_inprogress), 32'd1);
      check("rv_busy", 32'(result_valid), 32'd0);
      check("busy_op", 32'(busy_op), 32'(op));
      check("ready_busy", 32'(issue_ready), 32'd0);
      tick();
    end
    #1;
    check("rv_done", 32'(result_valid), 32'd1);
    check("inprogress_done", 32'(fpu_inprogress), 32'd0);
    check("result_done", fpu_result, res);
    check("illegal_done", 32'(illegal_op), 32'(ill));
    check("ready_done", 32'(issue_ready), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < NUM_OPS; k++) unit_results[k*WIDTH +: WIDTH] = slot(k);
    clock_reset = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = '0;
    tick();
    tick();
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_result", fpu_result, 32'd0);
    check("rst_busy_op", 32'(busy_op), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_perf_ops", perf_ops, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
    clock_reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();

    // op2, latency 5
    do_op(4'd2, 5, slot(2), 1'b0);
    tick();
    #1;
    check("rv_after_op2", 32'(result_valid), 32'd0);
    check("hold_after_op2", fpu_result, slot(2));

    // illegal op12
    do_op(4'd12, 0, 32'd0, 1'b1);
    tick();
    #1;
    check("illegal_clear", 32'(illegal_op), 32'd0);

    // op4 latency 0, op6 latency 16
    do_op(4'd4, 0, slot(4), 1'b0);
    tick();
    do_op(4'd6, 16, slot(6), 1'b0);
    tick();

    // back-to-back: op0 issued in op5's DONE cycle
    do_op(4'd5, 1, slot(5), 1'b0);
    do_op(4'd0, 7, slot(0), 1'b0);
    tick();
    #1;
    check("rv_after_b2b", 32'(result_valid), 32'd0);

    // flush at T+3 of op3
    issue_valid = 1'b1;
    issue_op    = 4'd3;
    tick();
    issue_valid = 1'b0;
    issue_op    = '0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("flush_inprog_T3", 32'(fpu_inprogress), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("flush_inprog", 32'(fpu_inprogress), 32'd0);
    check("flush_busy_op", 32'(busy_op), 32'd0);
    check("flush_ready", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("flush_no_rv", 32'(result_valid), 32'd0);
      tick();
    end
    check("flush_result_kept", fpu_result, slot(0));

    // flush together with issue_valid discards the issue
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 4'd4;
    #1;
    check("flush_issue_inprog", 32'(fpu_inprogress), 32'd0);
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = '0;
    #1;
    check("flush_issue_rv", 32'(result_valid), 32'd0);
    check("flush_issue_busy", 32'(busy_op), 32'd0);
    check("flush_issue_ready", 32'(issue_ready), 32'd1);

    // async reset mid-op
    issue_valid = 1'b1;
    issue_op    = 4'd6;
    tick();
    issue_valid = 1'b0;
    issue_op    = '0;
    tick();
    tick();
    #2;
    clock_reset = 1'b0;
    #1;
    check("arst_busy_op", 32'(busy_op), 32'd0);
    check("arst_inprog", 32'(fpu_inprogress), 32'd0);
    check("arst_result", fpu_result, 32'd0);
    check("arst_perf_ops", perf_ops, 32'd0);
    tick();
    clock_reset = 1'b1;
    tick();

    // perf: L=7 then L=1
    do_op(4'd0, 7, slot(0), 1'b0);
    tick();
    do_op(4'd5, 1, slot(5), 1'b0);
    tick();
    #1;
`ifdef FPU_SEQ_PERF_CNT_EN
    check("perf_ops", perf_ops, 32'd2);
    check("perf_stall", perf_stall, 32'd10);
`else
    check("perf_ops", perf_ops, 32'd0);
    check("perf_stall", perf_stall, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
